tm1640_bus_decoder: RTL and testbench
=====================================

// Module: tm1640_bus_decoder
// PURPOSE
//  Passive decoder for the two-wire LED-driver bus (SCLK/DIN, TM1640-style) that our pixel writer drives.
//  Oversamples both lines on CLK and detects START/STOP conditions. Reassembles LSB-first bytes and decodes
//  data/address/display-control commands into a 16-entry frame-buffer write port plus display state.
//  Used for loopback self-check of the LED array firmware and as an emulated display target in simulation.
// PARAMETERS
//  NUM_DIGITS   16  number of valid grid addresses (1..16); writes at addr >= NUM_DIGITS are suppressed
//  SYNC_STAGES  2   synchronizer flops on i_sclk and i_din (>=2)
// PORTS
//  CLK            in   1  system clock; single clock domain
//  RST            in   1  reset, synchronous, active-high
//  i_sclk         in   1  bus clock from the pixel writer (asynchronous to CLK)
//  i_din          in   1  bus data from the pixel writer (asynchronous to CLK)
//  o_wr_en        out  1  one-cycle pulse: write o_wr_data to grid o_wr_addr
//  o_wr_addr      out  4  grid address of the current write
//  o_wr_data      out  8  segment/pixel byte of the current write
//  o_display_on   out  1  display-enable bit from the last display-control command
//  o_brightness   out  3  brightness from the last display-control command
//  o_auto_inc     out  1  1 = auto-increment addressing, 0 = fixed address
//  o_busy         out  1  high from START detect until STOP detect
//  o_frame_err    out  1  one-cycle pulse on any protocol violation (see below)
// BEHAVIOUR
//  Reset: all outputs 0 except o_auto_inc=1; internal addr ptr=0, bit count=0, FSM=IDLE, sync flops=1.
//  Sync: i_sclk/i_din pass through SYNC_STAGES flops, then one history flop used for edge detection.
//   Pin-to-event latency is SYNC_STAGES+1 cycles.
//  START: DIN falls while SCLK is high in both current and previous sample. STOP: DIN rises under the
//   same condition. If SCLK and DIN change in the same sample, the change is data, not START/STOP.
//  Bit capture: on each synced SCLK rising edge, shift DIN in LSB first (sr <= {din, sr[7:1]}).
//   The byte completes on the 8th rise, and the bit count returns to 0. The protocol has no ACK bit.
//  FSM: IDLE -START-> CMD. CMD on byte complete decodes b[7:6]:
//   01 data cmd: o_auto_inc <= ~b[2] -> WAIT_STOP.
//   11 addr cmd: ptr <= b[3:0] -> DATA.
//   10 display ctrl: o_display_on <= b[3], o_brightness <= b[2:0] -> WAIT_STOP.
//   00 invalid: o_frame_err -> WAIT_STOP.
//  DATA: each complete byte causes o_wr_en=1 for one cycle, on the cycle after the 8th SCLK rise is
//   detected, with o_wr_addr=ptr and o_wr_data=byte. If o_auto_inc=1, ptr increments mod 16 (15->0).
//   Otherwise ptr is held. If ptr >= NUM_DIGITS, the write is suppressed and o_frame_err pulses instead.
//  WAIT_STOP: further complete bytes are ignored and each pulses o_frame_err.
//  STOP in any state -> IDLE, o_busy=0. If bit count != 0, the partial byte is discarded and
//   o_frame_err pulses.
//  START while o_busy (repeated start) -> CMD. Any partial byte is discarded silently (no error).
//  SCLK edges while IDLE are ignored and the bit count is held at 0.
//  o_wr_addr/o_wr_data hold their last values between pulses. The decoder never drives the bus.
//  RST asserted mid-frame returns to the reset state next cycle. No write or error pulse is produced
//   for the aborted frame. The decoder resyncs on the next START.
//  Minimum bus timing: each SCLK high/low phase must be >= SYNC_STAGES+2 CLK cycles. Faster input
//   is out of spec and its behaviour is undefined.
// TESTING
//  1 frame {START,0x8F,STOP} -> o_display_on=1, o_brightness=7, no o_wr_en, no o_frame_err.
//  2 {START,0xC3,0xA5,STOP} -> exactly one o_wr_en pulse with addr=3, data=0xA5; o_busy high
//    START..STOP only.
//  3 {START,0x40,STOP} then {START,0xC0, 17 bytes 0x00..0x10,STOP} -> writes at addr 0..15 then
//    addr 0 with data 0x10.
//  4 {START,0x44,STOP} then {START,0xC5,0x11,0x22,0x33,STOP} -> three writes, all addr=5; o_auto_inc=0.
//  5 {START,0xC2, 5 bits, STOP} -> one o_frame_err pulse, no o_wr_en; the next valid frame decodes
//    normally.
//  6 RST pulsed after 4 bits of a data byte -> outputs at reset values; a following
//    {START,0xC1,0x5A,STOP} writes addr 1.

Source files
------------

// File: rtl/tm1640_bus_decoder.sv
// Passive TM1640-style SCLK/DIN bus decoder: synchronizes the two wires,
// detects START/STOP, reassembles LSB-first bytes and decodes commands.
module tm1640_bus_decoder #(
  parameter int NUM_DIGITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_sclk,
  input  logic       i_din,
  output logic       o_wr_en,
  output logic [3:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_display_on,
  output logic [2:0] o_brightness,
  output logic       o_auto_inc,
  output logic       o_busy,
  output logic       o_frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic sclk_h_q, din_h_q;
  logic sclk_s, din_s;

  state_t state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] ptr_q, ptr_d;
  logic       wr_en_q, wr_en_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       don_q, don_d;
  logic [2:0] bri_q, bri_d;
  logic       ainc_q, ainc_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic sclk_rise, start_ev, stop_ev, ptr_ok;
  logic [7:0] byte_w;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  // Both samples must see SCLK high, so a DIN change that coincides
  // with an SCLK change is treated as data.
  assign sclk_rise = sclk_s & ~sclk_h_q;
  assign start_ev  = sclk_s & sclk_h_q & din_h_q & ~din_s;
  assign stop_ev   = sclk_s & sclk_h_q & ~din_h_q & din_s;
  assign byte_w    = {din_s, sr_q[7:1]};
  assign ptr_ok    = ({28'd0, ptr_q} < 32'(NUM_DIGITS));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    ptr_d   = ptr_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    don_d   = don_q;
    bri_d   = bri_q;
    ainc_d  = ainc_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    if (stop_ev) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      err_d   = (bcnt_q != 3'd0);
      bcnt_d  = 3'd0;
    end else if (start_ev) begin
      state_d = CMD;
      busy_d  = 1'b1;
      bcnt_d  = 3'd0;
    end else if (sclk_rise && state_q != IDLE) begin
      sr_d   = byte_w;
      bcnt_d = bcnt_q + 3'd1;
      if (bcnt_q == 3'd7) begin
        case (state_q)
          CMD: begin
            case (byte_w[7:6])
              2'b01: begin
                ainc_d  = ~byte_w[2];
                state_d = WAIT_STOP;
              end
              2'b11: begin
                ptr_d   = byte_w[3:0];
                state_d = DATA;
              end
              2'b10: begin
                don_d   = byte_w[3];
                bri_d   = byte_w[2:0];
                state_d = WAIT_STOP;
              end
              default: begin
                err_d   = 1'b1;
                state_d = WAIT_STOP;
              end
            endcase
          end
          DATA: begin
            if (ptr_ok) begin
              wr_en_d = 1'b1;
              addr_d  = ptr_q;
              data_d  = byte_w;
            end else begin
              err_d = 1'b1;
            end
            if (ainc_q) ptr_d = ptr_q + 4'd1;
          end
          WAIT_STOP: err_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_sync_q <= '1;
      din_sync_q  <= '1;
      sclk_h_q    <= 1'b1;
      din_h_q     <= 1'b1;
      state_q     <= IDLE;
      bcnt_q      <= 3'd0;
      sr_q        <= 8'd0;
      ptr_q       <= 4'd0;
      wr_en_q     <= 1'b0;
      addr_q      <= 4'd0;
      data_q      <= 8'd0;
      don_q       <= 1'b0;
      bri_q       <= 3'd0;
      ainc_q      <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], i_din};
      sclk_h_q    <= sclk_s;
      din_h_q     <= din_s;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      don_q       <= don_d;
      bri_q       <= bri_d;
      ainc_q      <= ainc_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = data_q;
  assign o_display_on = don_q;
  assign o_brightness = bri_q;
  assign o_auto_inc   = ainc_q;
  assign o_busy       = busy_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_tm1640_bus_decoder.sv
// Bench for tm1640_bus_decoder: command table plus hand-written frames,
// writes checked through an expected-write queue.
module tb_tm1640_bus_decoder;

  localparam int PH = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       din = 1'b1;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       disp_on;
  logic [2:0] bri;
  logic       ainc;
  logic       busy;
  logic       ferr;

  tm1640_bus_decoder #(
    .NUM_DIGITS (16),
    .SYNC_STAGES(2)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .i_sclk      (sclk),
    .i_din       (din),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_display_on(disp_on),
    .o_brightness(bri),
    .o_auto_inc  (ainc),
    .o_busy      (busy),
    .o_frame_err (ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] cmd;
    logic       on;
    logic [2:0] bri;
    logic       ainc;
    int         errs;
  } vec_t;

  wr_t sb[$];
  int total = 0;
  int bad = 0;
  int got_err = 0;
  int exp_err = 0;

  always @(negedge clk) begin
    if (ferr) got_err++;
    if (wr_en) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%02h exp none",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          bad++;
          $display("FAIL write got addr=%0d data=%02h exp addr=%0d data=%02h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic wc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic bus_start();
    din = 1'b0;
    wc(PH);
  endtask

  task automatic send_bit(input logic b);
    sclk = 1'b0;
    wc(PH);
    din = b;
    wc(PH);
    sclk = 1'b1;
    wc(PH);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  // SCLK stays high after the last bit; if DIN is high it must first
  // drop (a harmless repeated start) so that it can rise as STOP.
  task automatic bus_stop();
    if (din) begin
      din = 1'b0;
      wc(PH);
    end
    din = 1'b1;
    wc(PH);
    wc(10);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{cmd: 8'h8F, on: 1'b1, bri: 3'd7, ainc: 1'b1, errs: 0};
    tbl[1] = '{cmd: 8'h44, on: 1'b1, bri: 3'd7, ainc: 1'b0, errs: 0};
    tbl[2] = '{cmd: 8'h8A, on: 1'b1, bri: 3'd2, ainc: 1'b0, errs: 0};
    tbl[3] = '{cmd: 8'h00, on: 1'b1, bri: 3'd2, ainc: 1'b0, errs: 1};
    tbl[4] = '{cmd: 8'h40, on: 1'b1, bri: 3'd2, ainc: 1'b1, errs: 0};
    tbl[5] = '{cmd: 8'h80, on: 1'b0, bri: 3'd0, ainc: 1'b1, errs: 0};

    wc(4);
    rst = 1'b0;
    wc(4);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_on", 32'(disp_on), 32'd0);
    chk("reset_bri", 32'(bri), 32'd0);
    chk("reset_ainc", 32'(ainc), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(ferr), 32'd0);

    for (int i = 0; i < 6; i++) begin
      bus_start();
      send_byte(tbl[i].cmd);
      bus_stop();
      exp_err += tbl[i].errs;
      chk($sformatf("tbl%0d_on", i), 32'(disp_on), 32'(tbl[i].on));
      chk($sformatf("tbl%0d_bri", i), 32'(bri), 32'(tbl[i].bri));
      chk($sformatf("tbl%0d_ainc", i), 32'(ainc), 32'(tbl[i].ainc));
      chk($sformatf("tbl%0d_errs", i), 32'(got_err), 32'(exp_err));
    end

    // single write, busy framing
    chk("busy_pre", 32'(busy), 32'd0);
    bus_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    push_wr(4'd3, 8'hA5);
    send_byte(8'hC3);
    send_byte(8'hA5);
    chk("busy_before_stop", 32'(busy), 32'd1);
    bus_stop();
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("single_wr_pending", 32'(sb.size()), 32'd0);
    chk("hold_addr", 32'(wr_addr), 32'd3);
    chk("hold_data", 32'(wr_data), 32'hA5);

    // auto-increment with wrap 15 -> 0
    bus_start();
    send_byte(8'h40);
    bus_stop();
    bus_start();
    send_byte(8'hC0);
    for (int i = 0; i < 17; i++) begin
      push_wr(4'(i % 16), 8'(i));
      send_byte(8'(i));
    end
    bus_stop();
    chk("autoinc_pending", 32'(sb.size()), 32'd0);
    chk("autoinc_errs", 32'(got_err), 32'(exp_err));

    // fixed address
    bus_start();
    send_byte(8'h44);
    bus_stop();
    chk("fixed_ainc", 32'(ainc), 32'd0);
    bus_start();
    send_byte(8'hC5);
    push_wr(4'd5, 8'h11);
    send_byte(8'h11);
    push_wr(4'd5, 8'h22);
    send_byte(8'h22);
    push_wr(4'd5, 8'h33);
    send_byte(8'h33);
    bus_stop();
    chk("fixed_pending", 32'(sb.size()), 32'd0);

    // extra byte after a non-address command
    bus_start();
    send_byte(8'h8F);
    send_byte(8'h00);
    bus_stop();
    exp_err++;
    chk("waitstop_errs", 32'(got_err), 32'(exp_err));

    // partial byte at STOP
    bus_start();
    send_byte(8'hC2);
    for (int i = 0; i < 5; i++) send_bit(i[0] == 1'b0 && i < 4 ? 1'b1 : 1'b0);
    bus_stop();
    exp_err++;
    chk("partial_errs", 32'(got_err), 32'(exp_err));
    bus_start();
    send_byte(8'hC7);
    push_wr(4'd7, 8'h99);
    send_byte(8'h99);
    bus_stop();
    chk("after_partial_pending", 32'(sb.size()), 32'd0);

    // reset mid data byte
    bus_start();
    send_byte(8'hC2);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    wc(2);
    rst = 1'b0;
    wc(2);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_on", 32'(disp_on), 32'd0);
    chk("rst_ainc", 32'(ainc), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    wc(10);
    bus_start();
    send_byte(8'hC1);
    push_wr(4'd1, 8'h5A);
    send_byte(8'h5A);
    bus_stop();
    chk("post_rst_pending", 32'(sb.size()), 32'd0);
    chk("final_errs", 32'(got_err), 32'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
